// File: rtl/c_ctrl.sv
// c_ctrl: unary-word decoder (normal or complimented form) feeding a 2-entry result queue,
// with saturating admitted/inadmissible word counters.
module c_ctrl #(
  parameter int W = 16,
  parameter int P_ADMIT_COMPLIMENT_EN = 1,
  parameter int P_DROP_INVALID = 0,
  localparam int CW = $clog2(W + 1),
  localparam int EW = CW + 2
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          i_in_vld,
  input  logic [W-1:0]  i_in_x,
  output logic          o_in_rdy,
  output logic          o_out_vld,
  input  logic          i_out_rdy,
  output logic [CW-1:0] o_out_cnt,
  output logic          o_out_is_compliment,
  output logic          o_out_err,
  input  logic          i_clr_stats,
  output logic [15:0]   o_acc_cnt,
  output logic [15:0]   o_err_cnt
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  localparam logic [W-1:0] W_ONE = 1;
  state_t state, state_nx;
  logic comp, ok, in_t, out_t, enq;
  logic [W-1:0] y;
  logic [CW-1:0] pop;
  logic [EW-1:0] ent, q0, q1, q0_nx, q1_nx;
  assign comp = (P_ADMIT_COMPLIMENT_EN != 0) && i_in_x[W-1];
  // complimented words are inverted so both forms reduce to a 0^a 1^b check
  assign y = comp ? ~i_in_x : i_in_x;
  assign ok = (y & (y + W_ONE)) == '0;
  always_comb begin
    pop = '0;
    for (int i = 0; i < W; i++) pop = pop + CW'(y[i]);
  end
  assign ent = ok ? {1'b0, comp, pop} : {1'b1, 1'b0, {CW{1'b0}}};
  assign o_in_rdy = state != FULL;
  assign o_out_vld = state != EMPTY;
  assign {o_out_err, o_out_is_compliment, o_out_cnt} = q0;
  assign in_t = i_in_vld & o_in_rdy;
  assign out_t = o_out_vld & i_out_rdy;
  assign enq = in_t & (ok | (P_DROP_INVALID == 0));
  always_comb begin
    state_nx = state;
    q0_nx = q0;
    q1_nx = q1;
    case (state)
      EMPTY: if (enq) begin q0_nx = ent; state_nx = ONE; end
      ONE: begin
        if (enq && out_t) q0_nx = ent;
        else if (enq) begin q1_nx = ent; state_nx = FULL; end
        else if (out_t) state_nx = EMPTY;
      end
      FULL: if (out_t) begin q0_nx = q1; state_nx = ONE; end
      default: state_nx = EMPTY;
    endcase
  end
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      state <= EMPTY;
      q0 <= '0;
      q1 <= '0;
    end else begin
      state <= state_nx;
      q0 <= q0_nx;
      q1 <= q1_nx;
    end
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      o_acc_cnt <= '0;
      o_err_cnt <= '0;
    end else if (i_clr_stats) begin
      o_acc_cnt <= '0;
      o_err_cnt <= '0;
    end else if (in_t) begin
      o_acc_cnt <= o_acc_cnt + 16'(ok && o_acc_cnt != 16'hFFFF);
      o_err_cnt <= o_err_cnt + 16'(!ok && o_err_cnt != 16'hFFFF);
    end
endmodule

// File: doc/c_ctrl.md
C_CTRL -- requirements
Module: c_ctrl

Interface
REQ-001 Parameter W: default 16; input vector width, SHALL be >= 2.
REQ-002 Parameter P_ADMIT_COMPLIMENT_EN: default 1; when 1, the complimented unary form is admitted.
REQ-003 Parameter P_DROP_INVALID: default 0; when 1, inadmissible words are consumed but not forwarded.
REQ-004 Port clk, input, 1: sole clock; all state changes on the rising edge.
REQ-005 Port arst_n, input, 1: reset, asynchronous and active-low.
REQ-006 Port i_in_vld, input, 1: input word valid.
REQ-007 Port i_in_x, input, W: candidate unary word.
REQ-008 Port o_in_rdy, output, 1: block can accept a word this cycle.
REQ-009 Port o_out_vld, output, 1: result valid at the queue head.
REQ-010 Port i_out_rdy, input, 1: downstream accepts the head result.
REQ-011 Port o_out_cnt, output, $clog2(W+1): decoded unary value.
REQ-012 Port o_out_is_compliment, output, 1: result was decoded from the complimented form.
REQ-013 Port o_out_err, output, 1: word was inadmissible.
REQ-014 Port i_clr_stats, input, 1: synchronous clear of both statistics counters.
REQ-015 Port o_acc_cnt, output, 16: count of admitted words.
REQ-016 Port o_err_cnt, output, 16: count of inadmissible words.

Function
REQ-017 Input transfer SHALL occur when i_in_vld & o_in_rdy; output transfer SHALL occur when o_out_vld & i_out_rdy.
REQ-018 Normal form SHALL be 0^a 1^b with a+b=W, MSB-first, including all-zeros (cnt 0) and all-ones (cnt W); cnt = b.
REQ-019 If P_ADMIT_COMPLIMENT_EN=1 and i_in_x[W-1]=1, the word SHALL be checked only as complimented form 1^a 0^b; cnt = b; is_compliment=1; all-ones then gives cnt 0, is_compliment 1.
REQ-020 Otherwise the word SHALL be checked only as normal form; is_compliment=0.
REQ-021 An inadmissible word SHALL yield err=1, cnt=0, is_compliment=0.
REQ-022 Results SHALL pass through a 2-entry in-order queue; states EMPTY (0), ONE (1), FULL (2).
REQ-023 A word transferred at edge N SHALL have its result visible at the queue head from edge N+1 when the queue was EMPTY; latency is 1 cycle.
REQ-024 o_in_rdy SHALL be driven from registered state only and SHALL be 1 iff state != FULL; it SHALL have no combinational path from i_out_rdy.
REQ-025 Simultaneous enqueue and dequeue in ONE SHALL remain in ONE with the new result behind the departing head.
REQ-026 Dequeue in FULL SHALL move to ONE; o_in_rdy SHALL be 1 in the next cycle.
REQ-027 o_out_vld SHALL be 1 iff state != EMPTY; head fields SHALL stay stable while o_out_vld=1 and i_out_rdy=0.
REQ-028 If P_DROP_INVALID=1, an inadmissible word SHALL be consumed, counted, and not enqueued.
REQ-029 o_acc_cnt SHALL increment by 1 per admitted transferred word, saturating at 16'hFFFF.
REQ-030 o_err_cnt SHALL increment by 1 per inadmissible transferred word, saturating at 16'hFFFF.
REQ-031 i_clr_stats=1 SHALL set both counters to 0 at the next edge, overriding any same-cycle increment.
REQ-032 Admission logic SHALL be purely combinational from i_in_x; no state other than the queue, its state, and the counters.

Reset
REQ-033 On arst_n=0, the queue SHALL immediately become EMPTY: o_out_vld=0, o_in_rdy=1, o_out_cnt=0, o_out_is_compliment=0, o_out_err=0, o_acc_cnt=0, o_err_cnt=0.
REQ-034 Reset asserted mid-operation SHALL discard all queued results with no partial transfer; the first transfer after deassertion SHALL be accepted normally.

Verification
REQ-035 W=8, comp_en=1: input 8'b0000_0111, out_rdy=1 -> next cycle vld=1, cnt=3, is_compliment=0, err=0; acc_cnt=1.
REQ-036 W=8, comp_en=1: inputs 8'b1111_1000 then 8'hFF -> cnt=3/is_comp=1, then cnt=0/is_comp=1; with comp_en=0, 8'hFF -> cnt=8, is_comp=0, and 8'b1111_1000 -> err=1.
REQ-037 W=8: input 8'b0101_0000 -> err=1, cnt=0, err_cnt=1; with P_DROP_INVALID=1 -> no o_out_vld, err_cnt=1.
REQ-038 Backpressure: out_rdy=0, three back-to-back words -> two accepted, in_rdy=0 while FULL; raise out_rdy -> in_rdy=1 next cycle; results emerge in order, unchanged while stalled.
REQ-039 Stats: preload err_cnt to 16'hFFFF via 65535 bad words, send one more -> stays 16'hFFFF; assert i_clr_stats with a simultaneous good word -> acc_cnt=0.
REQ-040 Assert arst_n=0 while FULL -> o_out_vld=0, o_in_rdy=1 immediately; deassert, send 8'h01 -> cnt=1 after 1 cycle.
